decode_stage: RTL and testbench

Registered, multi-cycle-aware instruction decode stage for the pico MIPS core. It is the successor to the purely combinational decoder.
- Accepts one opcode per cycle through a valid/ready handshake.
- Produces registered control signals one cycle later.
- Holds off new instructions while a multi-cycle MULT completes.
- Squashes a configurable number of wrong-path instructions after a taken branch.
- Sits between instruction fetch and the register file/ALU.

---
 rtl/decode_stage.sv | 163 ++++++++++++++++
 tb/tb_decode_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage -- registered pico MIPS decode stage with MULT hold-off and branch squash (rev 1.0)
`default_nettype none

module decode_stage #(
  parameter int OPCODE_W     = 6,
  parameter int ALU_FUNC_W   = 3,
  parameter int MULT_CYCLES  = 3,
  parameter int BRANCH_FLUSH = 1
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic                  ZF,
  input  logic                  stall,
  output logic                  out_valid,
  output logic [ALU_FUNC_W-1:0] alu_func,
  output logic                  reg_write,
  output logic                  immediate,
  output logic                  read_in,
  output logic                  write_out,
  output logic                  pc_rel_branch,
  output logic                  mult_busy,
  output logic                  flush,
  output logic                  illegal
);

  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_BNQ  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_MULT = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_STIN = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_LOUT = OPCODE_W'(10);

  localparam logic [ALU_FUNC_W-1:0] RADD = ALU_FUNC_W'(1);
  localparam logic [ALU_FUNC_W-1:0] RSUB = ALU_FUNC_W'(2);

  localparam logic [3:0] MULT_INIT  = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] FLUSH_INIT = 4'(BRANCH_FLUSH);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MULT_WAIT = 2'd1,
    FLUSH     = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] count;
  logic       accept;

  logic [ALU_FUNC_W-1:0] dec_alu;
  logic dec_rw, dec_imm, dec_ri, dec_wo, dec_br, dec_ill, dec_mult;

  assign in_ready = n_reset && !stall && (state != MULT_WAIT);
  assign accept   = in_valid && in_ready;

  always_comb begin
    dec_alu  = '0;
    dec_rw   = 1'b0;
    dec_imm  = 1'b0;
    dec_ri   = 1'b0;
    dec_wo   = 1'b0;
    dec_br   = 1'b0;
    dec_ill  = 1'b0;
    dec_mult = 1'b0;
    case (opcode)
      OP_ADD:  begin dec_alu = RADD; dec_rw = 1'b1; end
      OP_SUB:  begin dec_alu = RSUB; dec_rw = 1'b1; end
      OP_ADDI: begin dec_alu = RADD; dec_imm = 1'b1; dec_rw = 1'b1; end
      OP_SUBI: begin dec_alu = RSUB; dec_imm = 1'b1; dec_rw = 1'b1; end
      OP_BEQ:  dec_br = ZF;
      OP_BNQ:  dec_br = !ZF;
      OP_JMP:  dec_br = 1'b1;
      OP_MULT: begin dec_rw = 1'b1; dec_mult = 1'b1; end
      OP_STIN: begin dec_ri = 1'b1; dec_rw = 1'b1; end
      OP_LOUT: dec_wo = 1'b1;
      default: dec_ill = 1'b1;
    endcase
  end

  // Every unstalled edge rewrites all outputs, so controls never linger across bubbles.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state         <= RUN;
      count         <= '0;
      out_valid     <= 1'b0;
      alu_func      <= '0;
      reg_write     <= 1'b0;
      immediate     <= 1'b0;
      read_in       <= 1'b0;
      write_out     <= 1'b0;
      pc_rel_branch <= 1'b0;
      mult_busy     <= 1'b0;
      flush         <= 1'b0;
      illegal       <= 1'b0;
    end else if (!stall) begin
      out_valid     <= 1'b0;
      alu_func      <= '0;
      reg_write     <= 1'b0;
      immediate     <= 1'b0;
      read_in       <= 1'b0;
      write_out     <= 1'b0;
      pc_rel_branch <= 1'b0;
      mult_busy     <= 1'b0;
      flush         <= 1'b0;
      illegal       <= 1'b0;
      case (state)
        RUN: begin
          if (accept) begin
            if (dec_mult && (MULT_CYCLES > 1)) begin
              mult_busy <= 1'b1;
              count     <= MULT_INIT;
              state     <= MULT_WAIT;
            end else begin
              out_valid     <= 1'b1;
              alu_func      <= dec_alu;
              reg_write     <= dec_rw;
              immediate     <= dec_imm;
              read_in       <= dec_ri;
              write_out     <= dec_wo;
              pc_rel_branch <= dec_br;
              illegal       <= dec_ill;
              if (dec_br && (BRANCH_FLUSH != 0)) begin
                count <= FLUSH_INIT;
                state <= FLUSH;
              end
            end
          end
        end
        MULT_WAIT: begin
          if (count == 4'd1) begin
            out_valid <= 1'b1;
            reg_write <= 1'b1;
            count     <= '0;
            state     <= RUN;
          end else begin
            mult_busy <= 1'b1;
            count     <= count - 4'd1;
          end
        end
        FLUSH: begin
          if (accept) begin
            flush <= 1'b1;
            count <= count - 4'd1;
            if (count == 4'd1) state <= RUN;
          end
        end
        default: begin
          state <= RUN;
          count <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// tb_decode_stage -- table vectors, MULT/reset corner sequences and random traffic against a behavioural model (rev 1.0)
`default_nettype none

module tb_decode_stage;

  localparam int MC = 3;
  localparam int BF = 1;

  localparam logic [5:0] ADD = 6'd1, SUB = 6'd2, ADDI = 6'd3, SUBI = 6'd4, BEQ = 6'd5,
                         BNQ = 6'd6, JMP = 6'd7, MULT = 6'd8, STIN = 6'd9, LOUT = 6'd10;
  localparam logic [2:0] RADD = 3'd1, RSUB = 3'd2;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] opcode = '0;
  logic       ZF = 1'b0;
  logic       stall = 1'b0;
  logic       out_valid;
  logic [2:0] alu_func;
  logic       reg_write, immediate, read_in, write_out, pc_rel_branch, mult_busy, flush, illegal;

  decode_stage #(
    .OPCODE_W(6), .ALU_FUNC_W(3), .MULT_CYCLES(MC), .BRANCH_FLUSH(BF)
  ) dut (
    .clk(clk), .n_reset(n_reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .ZF(ZF), .stall(stall), .out_valid(out_valid),
    .alu_func(alu_func), .reg_write(reg_write), .immediate(immediate),
    .read_in(read_in), .write_out(write_out), .pc_rel_branch(pc_rel_branch),
    .mult_busy(mult_busy), .flush(flush), .illegal(illegal)
  );

  always #5 clk = ~clk;

  wire [11:0] outs = {out_valid, alu_func, reg_write, immediate, read_in, write_out,
                      pc_rel_branch, mult_busy, flush, illegal};

  int n_checks = 0;
  int n_fail   = 0;

  // Output bundle layout: ov[11] alu[10:8] rw[7] imm[6] ri[5] wo[4] br[3] busy[2] flush[1] ill[0]
  function automatic logic [11:0] pk(input logic ov, input logic [2:0] af, input logic rw,
                                     input logic imm, input logic ri, input logic wo,
                                     input logic br, input logic mb, input logic fl,
                                     input logic il);
    return {ov, af, rw, imm, ri, wo, br, mb, fl, il};
  endfunction

  function automatic logic [11:0] spec_ctl(input logic [5:0] op, input logic z);
    case (op)
      ADD:     return pk(1, RADD, 1, 0, 0, 0, 0, 0, 0, 0);
      SUB:     return pk(1, RSUB, 1, 0, 0, 0, 0, 0, 0, 0);
      ADDI:    return pk(1, RADD, 1, 1, 0, 0, 0, 0, 0, 0);
      SUBI:    return pk(1, RSUB, 1, 1, 0, 0, 0, 0, 0, 0);
      BEQ:     return pk(1, 0, 0, 0, 0, 0, z, 0, 0, 0);
      BNQ:     return pk(1, 0, 0, 0, 0, 0, !z, 0, 0, 0);
      JMP:     return pk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      MULT:    return pk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      STIN:    return pk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      LOUT:    return pk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      default: return pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endcase
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: remaining MULT edges, remaining squashes, predicted outputs.
  int         mult_left   = 0;
  int         squash_left = 0;
  logic [11:0] m_exp      = '0;

  task automatic model_reset();
    mult_left = 0;
    squash_left = 0;
    m_exp = '0;
  endtask

  task automatic model_step(input logic acc, input logic [5:0] op, input logic z, input logic st);
    logic [11:0] d;
    if (st) return;
    if (mult_left > 0) begin
      mult_left--;
      m_exp = (mult_left == 0) ? spec_ctl(MULT, 1'b0) : pk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    end else if (acc) begin
      if (squash_left > 0) begin
        m_exp = pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        squash_left--;
      end else if (op == MULT && MC > 1) begin
        m_exp = pk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        mult_left = MC - 1;
      end else begin
        d = spec_ctl(op, z);
        m_exp = d;
        if (d[3]) squash_left = BF;
      end
    end else begin
      m_exp = '0;
    end
  endtask

  task automatic cycle(input logic v, input logic [5:0] op, input logic z, input logic st);
    logic exp_rdy;
    @(negedge clk);
    in_valid = v; opcode = op; ZF = z; stall = st;
    #1;
    exp_rdy = !st && (mult_left == 0);
    chk("in_ready", {11'b0, in_ready}, {11'b0, exp_rdy});
    model_step(v && exp_rdy, op, z, st);
    @(posedge clk);
    #1;
    chk("controls", outs, m_exp);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    n_reset = 1'b0; in_valid = 1'b0; stall = 1'b0;
    #1;
    chk("reset_outputs", outs, 12'h000);
    chk("reset_in_ready", {11'b0, in_ready}, 12'h000);
    model_reset();
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  task automatic mult_run(input int st_start, input int st_len, output int lat);
    logic st;
    lat = -1;
    cycle(1, MULT, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      st = (k >= st_start) && (k < st_start + st_len);
      cycle(1, ADD, 0, st);
      if (out_valid && reg_write && alu_func == 3'd0) begin
        lat = k + 1;
        break;
      end
    end
  endtask

  typedef struct {
    logic        v;
    logic [5:0]  op;
    logic        z;
    logic        st;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[21];

  initial begin
    int lat;
    logic [11:0] fl_only, zero;
    fl_only = pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    zero    = '0;

    tbl[0]  = '{1, ADD,   0, 0, pk(1, RADD, 1, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1, SUB,   0, 0, pk(1, RSUB, 1, 0, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{1, ADDI,  0, 0, pk(1, RADD, 1, 1, 0, 0, 0, 0, 0, 0)};
    tbl[3]  = '{1, SUBI,  0, 0, pk(1, RSUB, 1, 1, 0, 0, 0, 0, 0, 0)};
    tbl[4]  = '{1, BEQ,   0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[5]  = '{1, BEQ,   1, 0, pk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
    tbl[6]  = '{1, ADD,   0, 0, fl_only};
    tbl[7]  = '{1, BNQ,   1, 0, pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[8]  = '{1, BNQ,   0, 0, pk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
    tbl[9]  = '{1, ADD,   0, 0, fl_only};
    tbl[10] = '{1, JMP,   0, 0, pk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
    tbl[11] = '{1, SUB,   1, 0, fl_only};
    tbl[12] = '{1, STIN,  0, 0, pk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0)};
    tbl[13] = '{1, LOUT,  0, 0, pk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0)};
    tbl[14] = '{1, 6'h3F, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[15] = '{0, ADD,   0, 0, zero};
    tbl[16] = '{1, ADD,   0, 1, zero};
    tbl[17] = '{1, BEQ,   1, 0, pk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
    tbl[18] = '{0, ADD,   0, 0, zero};
    tbl[19] = '{1, ADD,   0, 0, fl_only};
    tbl[20] = '{1, ADD,   0, 0, pk(1, RADD, 1, 0, 0, 0, 0, 0, 0, 0)};

    // Reset state while held
    #2;
    chk("reset_outputs", outs, 12'h000);
    chk("reset_in_ready", {11'b0, in_ready}, 12'h000);
    model_reset();
    @(negedge clk);
    n_reset = 1'b1;

    for (int i = 0; i < 21; i++) begin
      cycle(tbl[i].v, tbl[i].op, tbl[i].z, tbl[i].st);
      chk($sformatf("table[%0d]", i), outs, tbl[i].exp);
    end

    // MULT followed by a held-valid ADD: retires 3 cycles after acceptance
    mult_run(100, 0, lat);
    chk("mult_latency", 12'(lat), 12'(MC));
    cycle(1, ADD, 0, 0);
    chk("add_after_mult", outs, pk(1, RADD, 1, 0, 0, 0, 0, 0, 0, 0));

    // Four stalled cycles inside MULT_WAIT push retirement out by four
    mult_run(1, 4, lat);
    chk("mult_stall_latency", 12'(lat), 12'(MC + 4));
    cycle(0, ADD, 0, 0);

    // Reset on cycle 2 of a 3-cycle MULT
    cycle(1, MULT, 0, 0);
    cycle(0, ADD, 0, 0);
    pulse_reset();
    cycle(0, ADD, 0, 0);
    chk("ready_after_release", {11'b0, in_ready}, 12'h001);
    for (int i = 0; i < 4; i++) begin
      cycle(0, ADD, 0, 0);
      chk("no_mult_after_reset", {11'b0, out_valid}, 12'h000);
    end

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [5:0] op;
      int sel;
      sel = $urandom_range(0, 11);
      if (sel < 10)       op = 6'(sel + 1);
      else if (sel == 10) op = 6'($urandom);
      else                op = 6'h3F;
      if ($urandom_range(0, 199) == 0) pulse_reset();
      cycle($urandom_range(0, 3) != 0, op, 1'($urandom), $urandom_range(0, 4) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
